fc_argmax_stage: RTL
====================

Name: fc_argmax_stage

Overview:
- Downstream consumer of the fully connected layer stage.
- Accepts the layer's M-element output vector as a valid/ready stream of signed T-bit words.
- Tracks the running maximum and its position.
- Emits one result per vector, (index of maximum, maximum value), on a valid/ready output, for use as the classifier decision.

Parameters:
- M, 8, elements per vector (matches the upstream layer's M); M >= 1
- T, 16, data word width in bits (matches the upstream layer's T)
- IW, max($clog2(M),1), index width; localparam, not overridable

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- input_valid  input  1  upstream word valid
- input_ready  output  1  stage can accept a word
- input_data  input  T  signed upstream word
- output_valid  output  1  result valid
- output_ready  input  1  downstream accepts result
- output_index  output  IW  index (0..M-1) of the maximum element
- output_data  output  T  signed maximum value

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values: state=LOAD, element counter=0, best value=0, best index=0, output_valid=0, output_index=0, output_data=0.
- Two-state FSM, LOAD and OUT.
- Input handshake: beat accepted when input_valid && input_ready.
- input_ready = (state==LOAD), combinational from state only, with no dependence on input_valid.
- Output handshake: result consumed when output_valid && output_ready.
- LOAD state, on each accepted beat:
  - if counter==0, best value <= input_data and best index <= 0, unconditionally;
  - else if input_data > best value (signed compare, full T bits), best value <= input_data and best index <= counter;
  - equal values do not replace the best, so the first occurrence wins;
  - counter increments by 1.
- LOAD to OUT: on the accepted beat with counter==M-1. In the same edge:
  - output_index/output_data load the final best, including that last beat's comparison;
  - output_valid <= 1;
  - counter <= 0.
- LOAD with no accepted beat: all state holds. Input bubbles of any length are allowed.
- OUT state:
  - input_ready=0;
  - output_valid=1;
  - output_index/output_data held stable until the handshake.
- OUT to LOAD: on the output handshake.
  - output_valid <= 0; output_index/output_data keep their last values.
  - input_ready is high the following cycle.
- Latency: output_valid rises on the first clk edge after the M-th beat is sampled, i.e. visible 1 cycle after the last input handshake.
- Throughput: with output_ready tied high, one vector per M+1 cycles (1 bubble cycle per vector).
- M==1: each accepted beat goes directly to OUT with index 0.
- Reset asserted mid-vector or in OUT: the partial vector or pending result is discarded and all reset values apply next cycle. The first beat accepted after reset is element 0.
- No arithmetic is performed beyond the compare. Widths are preserved and there is no saturation.
- Counter width is IW bits and never exceeds M-1.

Optional Feature:
- Macro: FC_ARGMAX_TIE_LAST_EN
- Defined: replacement condition becomes input_data >= best value (for counter>0), so the last occurrence of the maximum wins.
- Undefined: strict > as above; the first occurrence wins.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Basic, ties: M=8, output_ready=1; feed 5,-3,100,7,0,100,2,-128 back-to-back -> output_valid 1 cycle after last beat.
  - Without macro: index=2, data=100.
  - With FC_ARGMAX_TIE_LAST_EN: index=5, data=100.
- All-negative, last-element max: feed -10,-20,-30,-40,-50,-60,-70,-5 -> index=7, data=-5; confirms the signed compare and the last-beat comparison are included.
- Backpressure: after a result, hold output_ready=0 for 10 cycles while input_valid=1 -> input_ready=0 and output_index/output_data stable for all 10 cycles; on output_ready=1, the handshake completes and input_ready=1 the next cycle.
- Bubbles and back-to-back:
  - Randomly gate input_valid (about 50%) over 4 vectors -> 4 results matching a reference model, none dropped or duplicated.
  - Continuous valid/ready -> results every 9 cycles.
- Reset mid-vector: accept 3 beats (1000,2,3), assert reset 1 cycle, then feed 1,2,3,4,5,6,7,8 -> single result index=7, data=8. No output_valid during or right after the reset, and no influence from the pre-reset 1000.
- Reset in OUT: assert reset while output_valid=1 and output_ready=0 -> next cycle output_valid=0, output_index=0, output_data=0, input_ready=1.

Source files
------------

// File: rtl/fc_argmax_stage.sv
// Streaming argmax over M-element signed vectors; emits (index, value) of the maximum per vector.
// Define FC_ARGMAX_TIE_LAST_EN to let the last occurrence of an equal maximum win.
module fc_argmax_stage #(
    parameter int unsigned M = 8,
    parameter int unsigned T = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [T-1:0]                     input_data,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] output_index,
    output logic [T-1:0]                     output_data
);

    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(M - 1);

    typedef enum logic {StLoad, StOut} state_e;

    state_e               state_q;
    logic [IW-1:0]        cnt_q;
    logic signed [T-1:0]  best_q;
    logic [IW-1:0]        best_idx_q;
    logic                 out_valid_q;
    logic [IW-1:0]        out_idx_q;
    logic [T-1:0]         out_data_q;

    logic                 accept;
    logic                 replace;
    logic signed [T-1:0]  best_d;
    logic [IW-1:0]        best_idx_d;

    assign input_ready  = (state_q == StLoad);
    assign accept       = input_valid && input_ready;
    assign output_valid = out_valid_q;
    assign output_index = out_idx_q;
    assign output_data  = out_data_q;

    // Candidate best including the current beat, so the final beat's comparison
    // can be captured into the output registers on the same edge.
    always_comb begin
`ifdef FC_ARGMAX_TIE_LAST_EN
        replace = ($signed(input_data) >= best_q);
`else
        replace = ($signed(input_data) > best_q);
`endif
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (cnt_q == '0) begin
            best_d     = $signed(input_data);
            best_idx_d = '0;
        end else if (replace) begin
            best_d     = $signed(input_data);
            best_idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        best_q     <= best_d;
                        best_idx_q <= best_idx_d;
                        if (cnt_q == LastIdx) begin
                            cnt_q       <= '0;
                            state_q     <= StOut;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= best_idx_d;
                            out_data_q  <= best_d;
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                end
                StOut: begin
                    if (output_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StLoad;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule
